// File: rtl/pipe_ctrl_stage.sv
// Parametrised pipeline register for control bundles: stall, flush, bubble masking, occupancy.
// Define PIPE_CTRL_PERF_EN to add the stall/bubble performance counters.
module pipe_ctrl_stage #(
  parameter int              WIDTH     = 2,
  parameter int              DEPTH     = 1,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] ctrl_i,
  output logic [WIDTH-1:0] ctrl_o,
  output logic             valid_o,
  output logic [2:0]       occ_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      bubble_cnt_o,
`endif
  output logic             busy_o
);

  generate
    if (WIDTH < 1 || WIDTH > 32 || DEPTH < 1 || DEPTH > 4) begin : g_bad_params
      $error("pipe_ctrl_stage: WIDTH must be 1..32 and DEPTH must be 1..4");
    end
  endgenerate

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_ctrl [DEPTH];
  logic [2:0]       r_occ;

  logic             w_shift;
  logic             w_in_valid;
  logic [WIDTH-1:0] w_in_ctrl;
  logic [2:0]       w_occ_inc;
  logic [2:0]       w_occ_dec;

  assign w_shift    = !flush_i && !stall_i;
  // Invalid inputs are replaced by the NOP bundle so stray write enables never travel.
  assign w_in_valid = valid_i;
  assign w_in_ctrl  = valid_i ? ctrl_i : NOP_VALUE;
  assign w_occ_inc  = {2'b00, valid_i};
  assign w_occ_dec  = {2'b00, r_valid[DEPTH-1]};

  // NOTE: every slot of the array is reset, because a stale bundle could carry an
  // asserted write enable into the datapath right after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_occ   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_ctrl[k] <= NOP_VALUE;
      end
    end else if (flush_i) begin
      r_valid <= '0;
      r_occ   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_ctrl[k] <= NOP_VALUE;
      end
    end else if (w_shift) begin
      // NOTE: non-blocking assignments let each slot read its neighbour's old value,
      // so the loop order does not matter.
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_ctrl[k]  <= r_ctrl[k-1];
      end
      r_valid[0] <= w_in_valid;
      r_ctrl[0]  <= w_in_ctrl;
      r_occ      <= r_occ + w_occ_inc - w_occ_dec;
    end
  end

  assign ctrl_o  = r_ctrl[DEPTH-1];
  assign valid_o = r_valid[DEPTH-1];
  assign occ_o   = r_occ;
  assign busy_o  = (r_occ != 3'd0);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;
  logic        w_stall_evt;
  logic        w_bubble_evt;

  assign w_stall_evt  = stall_i && !flush_i;
  assign w_bubble_evt = flush_i || (w_shift && !valid_i);

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_stall_evt)  r_stall_cnt  <= r_stall_cnt + 32'd1;
      if (w_bubble_evt) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign stall_cnt_o  = r_stall_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule

// File: doc/pipe_ctrl_stage.md
Name: pipe_ctrl_stage

Overview:
Parametrised pipeline register for control-signal bundles such as regwrite and memtoreg, carried between stages of the multi-cycle CPU pipeline (for example M->W).
- Generalises the fixed 2-bit, 1-deep, clock-only stage register: configurable bundle width and depth, stall, flush/bubble insertion, per-slot valid tracking and an occupancy counter.
- Sits between hazard unit and datapath stage registers; one instance per stage boundary.

Parameters:
WIDTH, 2, width of control bundle in bits (1..32)
DEPTH, 1, number of register slots, i.e. latency in cycles (1..4)
NOP_VALUE, 0, WIDTH-bit bundle loaded on reset, flush and bubble; must deassert all write enables

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset; 0 = reset asserted
stall_i  input  1  1 = hold all slots this cycle
flush_i  input  1  1 = clear all slots to bubble this cycle
valid_i  input  1  ctrl_i carries a real instruction
ctrl_i  input  WIDTH  incoming control bundle
ctrl_o  output  WIDTH  bundle of last slot (slot DEPTH-1)
valid_o  output  1  valid bit of last slot
occ_o  output  3  number of valid slots, 0..DEPTH
busy_o  output  1  occ_o != 0

Behaviour:
- Storage: slot[0..DEPTH-1], each {valid, ctrl}. Outputs are taken directly from slot[DEPTH-1] registers; no combinational path from any input to any output.
- Reset (reset==0, asynchronous, takes effect immediately, independent of clk):
  - every slot = {0, NOP_VALUE};
  - ctrl_o = NOP_VALUE, valid_o = 0, occ_o = 0, busy_o = 0.
- Release: reset is synchronously deasserted externally; first capture happens on the first rising edge with reset==1.
- Priority at each rising edge: flush_i > stall_i > normal shift.
- Flush:
  - all slots <= {0, NOP_VALUE}; occ_o <= 0; the ctrl_i/valid_i presented that cycle are discarded;
  - flush with stall asserted in the same cycle still flushes.
- Stall (flush_i==0): all slots and occ_o hold. An input presented during stall is not captured; upstream must hold it.
- Normal shift:
  - slot[k] <= slot[k-1] for k>=1;
  - slot[0] <= valid_i ? {1, ctrl_i} : {0, NOP_VALUE}. Bubble masking: invalid input never propagates non-NOP bits.
- Latency: an input accepted at edge n appears on ctrl_o/valid_o after edge n+DEPTH-1 (DEPTH=1: visible immediately after the capturing edge), provided no stall cycles intervene. Each stall cycle adds one cycle.
- Occupancy on a normal shift: occ <= occ + valid_i - slot[DEPTH-1].valid. It is a registered counter, not a popcount.
  - The counter can never exceed DEPTH or underflow.
  - DEPTH=1 with valid_i=1 and an already-valid slot keeps occ = 1.
- Back-to-back flushes: each cycle re-clears; the state stays empty.
- Reset mid-stall or mid-flush: reset wins, with the same values as above.
- Parameter legality: out-of-range DEPTH or WIDTH is an elaboration error, raised via a generate-time check.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: adds outputs stall_cnt_o[31:0] and bubble_cnt_o[31:0], both reset to 0 by reset.
  - stall_cnt_o increments on each edge with stall_i=1 and flush_i=0.
  - bubble_cnt_o increments on each normal shift with valid_i=0, and on each flush edge.
  - Both wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset check (WIDTH=2, DEPTH=1, NOP=0): assert reset=0 mid-cycle with a valid slot loaded -> ctrl_o=2'b00, valid_o=0, occ_o=0 immediately, without waiting for a clock edge.
2. Pass-through (DEPTH=3): drive valid_i=1 with ctrl_i=1,2,3 on consecutive edges -> ctrl_o shows 1,2,3 after edges 3,4,5; occ_o goes 1,2,3,3,3.
3. Stall (DEPTH=2): load A, B, then stall_i=1 for 2 cycles while ctrl_i=C -> ctrl_o holds A, occ_o=2; after release, B then C emerge.
4. Flush over stall (DEPTH=2): two valid slots loaded, flush_i=1 and stall_i=1 at the same edge -> valid_o=0, ctrl_o=NOP_VALUE, occ_o=0; the input that cycle is lost.
5. Bubble masking (WIDTH=2, NOP=0): valid_i=0 with ctrl_i=2'b11 -> slot captures 2'b00, valid_o=0; occ_o decrements as the valid entries drain.
6. With PIPE_CTRL_PERF_EN defined: 3 stall cycles, then 1 flush, then 2 bubbles -> stall_cnt_o=3, bubble_cnt_o=3; preload the counter at 32'hFFFFFFFF, apply one stall -> it wraps to 0.
